// File: rtl/pe_ns_pkg.sv
// rtl/pe_ns_pkg.sv - shared types, flag encodings and helpers for the PE namespace (honours PE_NS_BYPASS_EN)
package pe_ns_pkg;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_sel_e;

  localparam logic FLAG_EMPTY = 1'b0;
  localparam logic FLAG_FULL  = 1'b1;

`ifdef PE_NS_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  function automatic bank_sel_e other_bank(input bank_sel_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

  // Entry 0 of the meta buffer identifies the PE; the rest start cleared.
  function automatic logic [31:0] meta_reset_value(input int pe_id, input int idx);
    return (idx == 0) ? 32'(pe_id) : 32'd0;
  endfunction

endpackage

// File: rtl/pe_ns_bank.sv
// rtl/pe_ns_bank.sv - single-port-write RAM with registered read and valid (PE_NS_BYPASS_EN adds write-to-read forwarding)
module pe_ns_bank
  import pe_ns_pkg::*;
#(
  parameter int addrLen = 5,
  parameter int dataLen = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wrt,
  input  logic [addrLen-1:0] wrt_addr,
  input  logic [dataLen-1:0] wrt_data,
  input  logic               rd,
  input  logic [addrLen-1:0] rd_addr,
  output logic [dataLen-1:0] rd_data,
  output logic               rd_vld
);

  logic [dataLen-1:0] mem [2**addrLen];
  logic               fwd;

  assign fwd = BYPASS_EN && wrt && (wrt_addr == rd_addr);

  // Storage is deliberately not reset; only the read port state is.
  always_ff @(posedge clk) begin
    if (wrt) mem[wrt_addr] <= wrt_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd;
      if (rd) rd_data <= fwd ? wrt_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/pe_namespace_pingpong.sv
// rtl/pe_namespace_pingpong.sv - PE namespace: ping-pong data banks, weight/grad RAMs, writable meta (PE_NS_BYPASS_EN)
module pe_namespace_pingpong
  import pe_ns_pkg::*;
#(
  parameter int dataLen       = 32,
  parameter int dataAddrLen   = 5,
  parameter int weightAddrLen = 5,
  parameter int gradAddrLen   = 4,
  parameter int metaAddrLen   = 2,
  parameter int peId          = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_wrt,
  input  logic [dataAddrLen-1:0]   data_wrt_addr,
  input  logic [dataLen-1:0]       data_in,
  input  logic                     data_load_done,
  input  logic                     data_release,
  output logic                     data_ready,
  input  logic                     data_rd,
  input  logic [dataAddrLen-1:0]   data_rd_addr,
  output logic [dataLen-1:0]       data_out,
  output logic                     data_out_vld,
  output logic                     data_wr_err,
  input  logic                     weight_wrt,
  input  logic [weightAddrLen-1:0] weight_wrt_addr,
  input  logic [dataLen-1:0]       weight_in,
  input  logic                     weight_rd,
  input  logic [weightAddrLen-1:0] weight_rd_addr,
  output logic [dataLen-1:0]       weight_out,
  output logic                     weight_out_vld,
  input  logic                     grad_wrt,
  input  logic [gradAddrLen-1:0]   grad_wrt_addr,
  input  logic [dataLen-1:0]       grad_in,
  input  logic                     grad_rd,
  input  logic [gradAddrLen-1:0]   grad_rd_addr,
  output logic [dataLen-1:0]       grad_out,
  output logic                     grad_out_vld,
  input  logic                     meta_wrt,
  input  logic [metaAddrLen-1:0]   meta_wrt_addr,
  input  logic [dataLen-1:0]       meta_in,
  input  logic                     meta_rd,
  input  logic [metaAddrLen-1:0]   meta_rd_addr,
  output logic [dataLen-1:0]       meta_out,
  output logic                     meta_out_vld
);

  logic               load_full, load_full_n;
  logic               comp_full, comp_full_n;
  bank_sel_e          load_sel, load_sel_n;
  logic               data_wr_ok;
  logic [1:0]         bank_wrt;
  logic [1:0]         bank_rd;
  logic [dataLen-1:0] bank_out [2];
  logic [1:0]         bank_vld;
  bank_sel_e          rd_bank_q;
  logic               rd_blank_q;
  logic [dataLen-1:0] meta_mem [2**metaAddrLen];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_full <= FLAG_EMPTY;
      comp_full <= FLAG_EMPTY;
      load_sel  <= BANK_0;
    end else begin
      load_full <= load_full_n;
      comp_full <= comp_full_n;
      load_sel  <= load_sel_n;
    end
  end

  // A simultaneous release + load_done on a full load bank swaps at once so
  // the PE never sees data_ready drop between samples.
  always_comb begin
    load_full_n = load_full;
    comp_full_n = comp_full;
    load_sel_n  = load_sel;
    if ((load_full == FLAG_FULL) &&
        ((comp_full == FLAG_EMPTY) || (data_release && data_load_done))) begin
      load_sel_n  = other_bank(load_sel);
      comp_full_n = FLAG_FULL;
      load_full_n = FLAG_EMPTY;
    end else begin
      if (data_load_done) load_full_n = FLAG_FULL;
      if (data_release)   comp_full_n = FLAG_EMPTY;
    end
  end

  always_comb begin
    bank_wrt = '0;
    bank_rd  = '0;
    data_wr_ok = data_wrt && (load_full == FLAG_EMPTY);
    bank_wrt[load_sel] = data_wr_ok;
    bank_rd[other_bank(load_sel)] = data_rd && (comp_full == FLAG_FULL);
  end

  assign data_ready = comp_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_wr_err <= 1'b0;
      rd_bank_q   <= BANK_0;
      rd_blank_q  <= 1'b0;
    end else begin
      if (data_wrt && (load_full == FLAG_FULL)) data_wr_err <= 1'b1;
      if (data_rd) begin
        rd_bank_q  <= other_bank(load_sel);
        rd_blank_q <= (comp_full == FLAG_EMPTY);
      end
    end
  end

  // A read with no sample ready returns zero without a valid strobe.
  assign data_out     = rd_blank_q ? '0 : bank_out[rd_bank_q];
  assign data_out_vld = |bank_vld;

  for (genvar b = 0; b < 2; b++) begin : g_data_bank
    pe_ns_bank #(.addrLen(dataAddrLen), .dataLen(dataLen)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wrt      (bank_wrt[b]),
      .wrt_addr (data_wrt_addr),
      .wrt_data (data_in),
      .rd       (bank_rd[b]),
      .rd_addr  (data_rd_addr),
      .rd_data  (bank_out[b]),
      .rd_vld   (bank_vld[b])
    );
  end

  pe_ns_bank #(.addrLen(weightAddrLen), .dataLen(dataLen)) u_weight (
    .clk      (clk),
    .reset    (reset),
    .wrt      (weight_wrt),
    .wrt_addr (weight_wrt_addr),
    .wrt_data (weight_in),
    .rd       (weight_rd),
    .rd_addr  (weight_rd_addr),
    .rd_data  (weight_out),
    .rd_vld   (weight_out_vld)
  );

  pe_ns_bank #(.addrLen(gradAddrLen), .dataLen(dataLen)) u_grad (
    .clk      (clk),
    .reset    (reset),
    .wrt      (grad_wrt),
    .wrt_addr (grad_wrt_addr),
    .wrt_data (grad_in),
    .rd       (grad_rd),
    .rd_addr  (grad_rd_addr),
    .rd_data  (grad_out),
    .rd_vld   (grad_out_vld)
  );

  // Meta lives in flops so entry 0 can come out of reset holding the PE id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**metaAddrLen; i++) begin
        meta_mem[i] <= dataLen'(meta_reset_value(peId, i));
      end
    end else if (meta_wrt) begin
      meta_mem[meta_wrt_addr] <= meta_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_out     <= '0;
      meta_out_vld <= 1'b0;
    end else begin
      meta_out_vld <= meta_rd;
      if (meta_rd) begin
        meta_out <= (BYPASS_EN && meta_wrt && (meta_wrt_addr == meta_rd_addr))
                    ? meta_in : meta_mem[meta_rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_pe_namespace_pingpong.sv
// tb/tb_pe_namespace_pingpong.sv - randomized and directed bench for pe_namespace_pingpong against a sample-level model
module tb_pe_namespace_pingpong;

  localparam int PE_ID = 3;
`ifdef PE_NS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        data_wrt, data_load_done, data_release, data_rd;
  logic [4:0]  data_wrt_addr, data_rd_addr;
  logic [31:0] data_in, data_out;
  logic        data_ready, data_out_vld, data_wr_err;
  logic        weight_wrt, weight_rd, weight_out_vld;
  logic [4:0]  weight_wrt_addr, weight_rd_addr;
  logic [31:0] weight_in, weight_out;
  logic        grad_wrt, grad_rd, grad_out_vld;
  logic [3:0]  grad_wrt_addr, grad_rd_addr;
  logic [31:0] grad_in, grad_out;
  logic        meta_wrt, meta_rd, meta_out_vld;
  logic [1:0]  meta_wrt_addr, meta_rd_addr;
  logic [31:0] meta_in, meta_out;

  pe_namespace_pingpong #(.peId(PE_ID)) dut (
    .clk(clk), .reset(reset),
    .data_wrt(data_wrt), .data_wrt_addr(data_wrt_addr), .data_in(data_in),
    .data_load_done(data_load_done), .data_release(data_release), .data_ready(data_ready),
    .data_rd(data_rd), .data_rd_addr(data_rd_addr), .data_out(data_out),
    .data_out_vld(data_out_vld), .data_wr_err(data_wr_err),
    .weight_wrt(weight_wrt), .weight_wrt_addr(weight_wrt_addr), .weight_in(weight_in),
    .weight_rd(weight_rd), .weight_rd_addr(weight_rd_addr), .weight_out(weight_out),
    .weight_out_vld(weight_out_vld),
    .grad_wrt(grad_wrt), .grad_wrt_addr(grad_wrt_addr), .grad_in(grad_in),
    .grad_rd(grad_rd), .grad_rd_addr(grad_rd_addr), .grad_out(grad_out),
    .grad_out_vld(grad_out_vld),
    .meta_wrt(meta_wrt), .meta_wrt_addr(meta_wrt_addr), .meta_in(meta_in),
    .meta_rd(meta_rd), .meta_rd_addr(meta_rd_addr), .meta_out(meta_out),
    .meta_out_vld(meta_out_vld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: the current sample and the sample being loaded, as plain arrays.
  logic [31:0] cur_s [32];
  logic [31:0] nxt_s [32];
  bit          cur_k [32];
  bit          nxt_k [32];
  logic [31:0] w_m [32];
  bit          w_k [32];
  logic [31:0] g_m [16];
  bit          g_k [16];
  logic [31:0] m_m [4];
  bit          loaded, computing, wr_err_m;
  logic [31:0] e_d, e_w, e_g, e_m;
  bit          e_d_v, e_w_v, e_g_v, e_m_v;
  bit          e_d_k, e_w_k, e_g_k;

  task automatic idle();
    data_wrt = 0; data_wrt_addr = 0; data_in = 0; data_load_done = 0; data_release = 0;
    data_rd = 0; data_rd_addr = 0;
    weight_wrt = 0; weight_wrt_addr = 0; weight_in = 0; weight_rd = 0; weight_rd_addr = 0;
    grad_wrt = 0; grad_wrt_addr = 0; grad_in = 0; grad_rd = 0; grad_rd_addr = 0;
    meta_wrt = 0; meta_wrt_addr = 0; meta_in = 0; meta_rd = 0; meta_rd_addr = 0;
  endtask

  task automatic model_reset();
    loaded = 0; computing = 0; wr_err_m = 0;
    for (int i = 0; i < 32; i++) begin cur_k[i] = 0; nxt_k[i] = 0; w_k[i] = 0; end
    for (int i = 0; i < 16; i++) g_k[i] = 0;
    for (int i = 0; i < 4; i++) m_m[i] = 0;
    m_m[0] = PE_ID;
    e_d = 0; e_w = 0; e_g = 0; e_m = 0;
    e_d_v = 0; e_w_v = 0; e_g_v = 0; e_m_v = 0;
    e_d_k = 1; e_w_k = 1; e_g_k = 1;
  endtask

  task automatic promote_sample();
    logic [31:0] t;
    bit          tk;
    for (int i = 0; i < 32; i++) begin
      t = cur_s[i]; cur_s[i] = nxt_s[i]; nxt_s[i] = t;
      tk = cur_k[i]; cur_k[i] = nxt_k[i]; nxt_k[i] = tk;
    end
    computing = 1;
    loaded = 0;
  endtask

  // Apply the inputs currently driven for one clock and check every output.
  task automatic step();
    e_d_v = 0; e_w_v = 0; e_g_v = 0; e_m_v = 0;
    if (data_rd) begin
      if (computing) begin
        e_d_v = 1; e_d = cur_s[data_rd_addr]; e_d_k = cur_k[data_rd_addr];
      end else begin
        e_d = 0; e_d_k = 1;
      end
    end
    if (weight_rd) begin
      e_w_v = 1;
      if (BYP && weight_wrt && weight_wrt_addr == weight_rd_addr) begin e_w = weight_in; e_w_k = 1; end
      else begin e_w = w_m[weight_rd_addr]; e_w_k = w_k[weight_rd_addr]; end
    end
    if (grad_rd) begin
      e_g_v = 1;
      if (BYP && grad_wrt && grad_wrt_addr == grad_rd_addr) begin e_g = grad_in; e_g_k = 1; end
      else begin e_g = g_m[grad_rd_addr]; e_g_k = g_k[grad_rd_addr]; end
    end
    if (meta_rd) begin
      e_m_v = 1;
      e_m = (BYP && meta_wrt && meta_wrt_addr == meta_rd_addr) ? meta_in : m_m[meta_rd_addr];
    end
    if (weight_wrt) begin w_m[weight_wrt_addr] = weight_in; w_k[weight_wrt_addr] = 1; end
    if (grad_wrt)   begin g_m[grad_wrt_addr] = grad_in; g_k[grad_wrt_addr] = 1; end
    if (meta_wrt)   m_m[meta_wrt_addr] = meta_in;
    if (data_wrt) begin
      if (loaded) wr_err_m = 1;
      else begin nxt_s[data_wrt_addr] = data_in; nxt_k[data_wrt_addr] = 1; end
    end
    if (loaded && !computing) promote_sample();
    else if (loaded && data_release && data_load_done) promote_sample();
    else begin
      if (data_load_done) loaded = 1;
      if (data_release)   computing = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("data_ready", 32'(data_ready), 32'(computing));
    check_eq("data_wr_err", 32'(data_wr_err), 32'(wr_err_m));
    check_eq("data_out_vld", 32'(data_out_vld), 32'(e_d_v));
    if (e_d_k) check_eq("data_out", data_out, e_d);
    check_eq("weight_out_vld", 32'(weight_out_vld), 32'(e_w_v));
    if (e_w_k) check_eq("weight_out", weight_out, e_w);
    check_eq("grad_out_vld", 32'(grad_out_vld), 32'(e_g_v));
    if (e_g_k) check_eq("grad_out", grad_out, e_g);
    check_eq("meta_out_vld", 32'(meta_out_vld), 32'(e_m_v));
    check_eq("meta_out", meta_out, e_m);
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    check_eq("rst_ready", 32'(data_ready), 0);
    check_eq("rst_err", 32'(data_wr_err), 0);
    check_eq("rst_dvld", 32'(data_out_vld), 0);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_meta", meta_out, 0);

    meta_rd = 1; meta_rd_addr = 0; step();
    check_eq("t1_meta0", meta_out, PE_ID);
    meta_rd = 1; meta_rd_addr = 1; step();
    check_eq("t1_meta1", meta_out, 0);

    for (int i = 0; i < 32; i++) begin
      data_wrt = 1; data_wrt_addr = 5'(i); data_in = i; step();
    end
    data_load_done = 1; step();
    step();
    check_eq("t2_ready", 32'(data_ready), 1);
    for (int i = 0; i < 32; i++) begin
      data_rd = 1; data_rd_addr = 7;
      data_wrt = 1; data_wrt_addr = 5'(i); data_in = i + 100; step();
      if (i == 0) check_eq("t2_rd7", data_out, 7);
    end
    data_load_done = 1; step();
    data_release = 1; step();
    step();
    data_rd = 1; data_rd_addr = 7; step();
    check_eq("t2_swap_rd7", data_out, 107);

    for (int i = 0; i < 32; i++) begin
      data_wrt = 1; data_wrt_addr = 5'(i); data_in = i + 200; step();
    end
    data_load_done = 1; step();
    data_wrt = 1; data_wrt_addr = 2; data_in = 32'hBAD; step();
    check_eq("t3_err", 32'(data_wr_err), 1);
    repeat (3) step();
    check_eq("t3_err_held", 32'(data_wr_err), 1);

    data_load_done = 1; data_release = 1; step();
    check_eq("t4_ready", 32'(data_ready), 1);
    data_rd = 1; data_rd_addr = 2; step();
    check_eq("t4_rd2", data_out, 202);

    weight_wrt = 1; weight_wrt_addr = 5; weight_in = 32'h1111_1111; step();
    weight_wrt = 1; weight_wrt_addr = 5; weight_in = 32'hDEAD_BEEF;
    weight_rd = 1; weight_rd_addr = 5; step();
    check_eq("t5_weight", weight_out, BYP ? 32'hDEAD_BEEF : 32'h1111_1111);
    meta_wrt = 1; meta_wrt_addr = 0; meta_in = 32'h55; step();

    data_load_done = 1; step();
    data_release = 1; weight_rd = 1; weight_rd_addr = 5; step();
    #2 reset = 1;
    #1;
    check_eq("t6_ready", 32'(data_ready), 0);
    check_eq("t6_err", 32'(data_wr_err), 0);
    check_eq("t6_wvld", 32'(weight_out_vld), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    meta_rd = 1; meta_rd_addr = 0; step();
    check_eq("t6_meta0", meta_out, PE_ID);
    data_rd = 1; data_rd_addr = 7; step();
    check_eq("t6_blank_rd", data_out, 0);

    for (int n = 0; n < 500; n++) begin
      data_wrt       = 1'($urandom);
      data_wrt_addr  = 5'($urandom);
      data_in        = $urandom;
      data_load_done = ($urandom % 12) == 0;
      data_release   = ($urandom % 10) == 0;
      data_rd        = 1'($urandom);
      data_rd_addr   = 5'($urandom);
      weight_wrt      = 1'($urandom);
      weight_wrt_addr = 5'($urandom);
      weight_in       = $urandom;
      weight_rd       = 1'($urandom);
      weight_rd_addr  = (($urandom % 4) == 0) ? weight_wrt_addr : 5'($urandom);
      grad_wrt      = 1'($urandom);
      grad_wrt_addr = 4'($urandom);
      grad_in       = $urandom;
      grad_rd       = 1'($urandom);
      grad_rd_addr  = (($urandom % 4) == 0) ? grad_wrt_addr : 4'($urandom);
      meta_wrt      = ($urandom % 4) == 0;
      meta_wrt_addr = 2'($urandom);
      meta_in       = $urandom;
      meta_rd       = 1'($urandom);
      meta_rd_addr  = 2'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
